// File: rtl/cdb_arbiter_if.sv
// Bus bundle between execution units and the CDB arbiter: per-unit result capture,
// flush, issue throttling and the single broadcast port.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

interface cdb_arbiter_if #(
  parameter int unsigned NUM_FU       = 3,
  parameter int unsigned FU_IDX_WIDTH = (NUM_FU <= 1) ? 1 : $clog2(NUM_FU)
);
  logic [NUM_FU-1:0]                           fu_valid;
  logic [NUM_FU*`REG_VAL_WIDTH-1:0]            fu_result_val;
  logic [NUM_FU*`PHYSICAL_REG_NUM_WIDTH-1:0]   fu_result_addr;
  logic [NUM_FU*`ROB_SIZE_WIDTH-1:0]           fu_tag;
  logic                                        flush;
  logic [NUM_FU-1:0]                           fu_ready;
  logic                                        cdb_valid;
  logic [`REG_VAL_WIDTH-1:0]                   cdb_val;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]          cdb_addr;
  logic [`ROB_SIZE_WIDTH-1:0]                  cdb_tag;
  logic [FU_IDX_WIDTH-1:0]                     cdb_src;
  logic                                        overflow_err;

  modport slave (
    input  fu_valid, fu_result_val, fu_result_addr, fu_tag, flush,
    output fu_ready, cdb_valid, cdb_val, cdb_addr, cdb_tag, cdb_src, overflow_err
  );

  modport master (
    output fu_valid, fu_result_val, fu_result_addr, fu_tag, flush,
    input  fu_ready, cdb_valid, cdb_val, cdb_addr, cdb_tag, cdb_src, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-unit result FIFOs drained one entry per cycle in
// round-robin order, with issue throttling and a sticky drop indicator.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module cdb_arbiter #(
  parameter int unsigned NUM_FU       = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READY_SLACK  = 2,
  parameter int unsigned FU_IDX_WIDTH = (NUM_FU <= 1) ? 1 : $clog2(NUM_FU)
) (
  input logic          clk,
  input logic          reset,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned VW   = `REG_VAL_WIDTH;
  localparam int unsigned AW   = `PHYSICAL_REG_NUM_WIDTH;
  localparam int unsigned TW   = `ROB_SIZE_WIDTH;
  localparam int unsigned EW   = VW + AW + TW;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [EW-1:0]           mem_q    [NUM_FU][FIFO_DEPTH];
  logic [EW-1:0]           mem_d    [NUM_FU][FIFO_DEPTH];
  logic [PtrW-1:0]         rd_ptr_q [NUM_FU];
  logic [PtrW-1:0]         rd_ptr_d [NUM_FU];
  logic [PtrW-1:0]         wr_ptr_q [NUM_FU];
  logic [PtrW-1:0]         wr_ptr_d [NUM_FU];
  logic [CntW-1:0]         cnt_q    [NUM_FU];
  logic [CntW-1:0]         cnt_d    [NUM_FU];
  logic [FU_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                    overflow_q, overflow_d;

  logic [FU_IDX_WIDTH-1:0] scan_idx [NUM_FU];
  logic                    grant_valid;
  logic [FU_IDX_WIDTH-1:0] grant_idx;
  logic [EW-1:0]           head;
  logic [NUM_FU-1:0]       pop_vec, full_vec, accept_vec;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Scan order starts at the round-robin pointer and wraps modulo NUM_FU.
  always_comb begin
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      scan_idx[k] = FU_IDX_WIDTH'((32'(rr_ptr_q) + k) % NUM_FU);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (!grant_valid && cnt_q[scan_idx[k]] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[k];
      end
    end
    head = '0;
    if (grant_valid) head = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  assign bus.cdb_valid    = grant_valid;
  assign bus.cdb_val      = head[EW-1 -: VW];
  assign bus.cdb_addr     = head[AW+TW-1 -: AW];
  assign bus.cdb_tag      = head[TW-1:0];
  assign bus.cdb_src      = grant_idx;
  assign bus.overflow_err = overflow_q;

  always_comb begin
    bus.fu_ready = '0;
    pop_vec      = '0;
    full_vec     = '0;
    accept_vec   = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      bus.fu_ready[i] = (FIFO_DEPTH - 32'(cnt_q[i])) >= READY_SLACK;
      pop_vec[i]      = grant_valid && (grant_idx == FU_IDX_WIDTH'(i));
      full_vec[i]     = cnt_q[i] == CntW'(FIFO_DEPTH);
      // A full FIFO still accepts when its head leaves in the same cycle.
      accept_vec[i]   = bus.fu_valid[i] && (!full_vec[i] || pop_vec[i]);
    end
  end

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    rr_ptr_d   = rr_ptr_q;

    if (grant_valid) begin
      rr_ptr_d = (32'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + FU_IDX_WIDTH'(1);
    end

    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (bus.flush) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (bus.fu_valid[i] && !accept_vec[i]) overflow_d = 1'b1;
        if (accept_vec[i]) begin
          mem_d[i][wr_ptr_q[i]] = {bus.fu_result_val[i*VW +: VW],
                                   bus.fu_result_addr[i*AW +: AW],
                                   bus.fu_tag[i*TW +: TW]};
          wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
        end
        if (pop_vec[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
        if (accept_vec[i] && !pop_vec[i]) begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end else if (pop_vec[i] && !accept_vec[i]) begin
          cnt_d[i] = cnt_q[i] - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      wr_ptr_q   <= '{default: '0};
      cnt_q      <= '{default: '0};
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end
endmodule
